riscy_data_mem_responder: RTL and testbench

RISCY_DATA_MEM_RESPONDER -- requirements
Module: riscy_data_mem_responder

---
 rtl/riscy_data_mem_responder.sv | 150 +++++++++++++++
 tb/tb_riscy_data_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscy_data_mem_responder.sv
// riscy_data_mem_responder
// Data-side memory model for the riscy core: a grant FSM with a
// configurable stall, a byte-enabled backing store, and a fixed-latency,
// in-order response pipeline with no back-pressure.
module riscy_data_mem_responder #(
    parameter int unsigned MEM_WORDS    = 256,
    parameter int unsigned RESP_LATENCY = 1,
    parameter int unsigned GNT_STALL    = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        GRANT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;

    logic        accept;
    logic [29:0] word_idx;
    logic        in_range;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0] rd_word;

    logic [31:0] mem [MEM_WORDS];

    logic [RESP_LATENCY-1:0] pipe_v;
    logic [RESP_LATENCY-1:0] pipe_err;
    logic [31:0]             pipe_data [RESP_LATENCY];

    assign word_idx = data_addr_i[31:2];
    assign in_range = ({2'b00, word_idx} < MEM_WORDS);
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign rd_word  = mem[mem_idx];
    assign accept   = data_req_i & data_gnt_o;

    // Grant FSM state and stall counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant FSM next-state logic
    // The IDLE cycle in which a request is seen counts as the first stall
    // cycle, so gnt stays low for exactly GNT_STALL cycles overall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    if (GNT_STALL <= 1) begin
                        state_d = GRANT;
                    end else begin
                        state_d = STALL;
                        cnt_d   = 2'(GNT_STALL - 1);
                    end
                end
            end
            STALL: begin
                if (!data_req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                if (!data_req_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Grant FSM output: with no stall configured, IDLE grants a pending
    // request in the same cycle; grants are suppressed while in reset.
    always_comb begin
        data_gnt_o = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                GRANT:   data_gnt_o = 1'b1;
                IDLE:    data_gnt_o = data_req_i && (GNT_STALL == 0);
                default: data_gnt_o = 1'b0;
            endcase
        end
    end

    // Backing store: byte-enabled write of accepted in-range requests
    always_ff @(posedge clk_i) begin
        if (accept && data_we_i && in_range) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (data_be_i[k]) begin
                    mem[mem_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Response pipeline: capture at acceptance, shift one stage per cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_v   <= '0;
            pipe_err <= '0;
        end else begin
            pipe_v[0]    <= accept;
            pipe_err[0]  <= accept & ~in_range;
            pipe_data[0] <= (accept && !data_we_i && in_range) ? rd_word : '0;
            for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_err[i]  <= pipe_err[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign data_rvalid_o = pipe_v[RESP_LATENCY-1];
    assign data_err_o    = pipe_v[RESP_LATENCY-1] & pipe_err[RESP_LATENCY-1];
    assign data_rdata_o  = pipe_v[RESP_LATENCY-1] ? pipe_data[RESP_LATENCY-1] : '0;

endmodule

// File: tb/tb_riscy_data_mem_responder.sv
// Directed bench for riscy_data_mem_responder.
// Instance a: no stall, latency 1. Instance b: stall 2, latency 3.
module tb_riscy_data_mem_responder;

    logic clk = 1'b0;
    logic rst;

    logic        a_req, a_gnt, a_we, a_rvalid, a_err;
    logic [3:0]  a_be;
    logic [31:0] a_addr, a_wdata, a_rdata;

    logic        b_req, b_gnt, b_we, b_rvalid, b_err;
    logic [3:0]  b_be;
    logic [31:0] b_addr, b_wdata, b_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscy_data_mem_responder #(
        .MEM_WORDS   (256),
        .RESP_LATENCY(1),
        .GNT_STALL   (0)
    ) dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_req_i   (a_req),
        .data_gnt_o   (a_gnt),
        .data_we_i    (a_we),
        .data_be_i    (a_be),
        .data_addr_i  (a_addr),
        .data_wdata_i (a_wdata),
        .data_rvalid_o(a_rvalid),
        .data_rdata_o (a_rdata),
        .data_err_o   (a_err)
    );

    riscy_data_mem_responder #(
        .MEM_WORDS   (256),
        .RESP_LATENCY(3),
        .GNT_STALL   (2)
    ) dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_req_i   (b_req),
        .data_gnt_o   (b_gnt),
        .data_we_i    (b_we),
        .data_be_i    (b_be),
        .data_addr_i  (b_addr),
        .data_wdata_i (b_wdata),
        .data_rvalid_o(b_rvalid),
        .data_rdata_o (b_rdata),
        .data_err_o   (b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One isolated transfer on instance a; called just after a rising edge.
    task automatic a_single(input string tag, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err);
        a_req = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata;
        @(negedge clk);
        chk({tag, " gnt"}, 32'(a_gnt), 32'd1);
        next_cycle();
        a_req = 1'b0;
        @(negedge clk);
        chk({tag, " rvalid"}, 32'(a_rvalid), 32'd1);
        chk({tag, " rdata"}, a_rdata, exp_rdata);
        chk({tag, " err"}, 32'(a_err), 32'(exp_err));
        next_cycle();
    endtask

    // One isolated transfer on instance b from IDLE: expects a two-cycle
    // stall and the response exactly three cycles after acceptance.
    task automatic b_single(input string tag, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err);
        int unsigned waited = 0;
        b_req = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wdata = wdata;
        @(negedge clk);
        while (b_gnt !== 1'b1 && waited < 8) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        chk({tag, " gnt"}, 32'(b_gnt), 32'd1);
        chk({tag, " stall"}, waited, 32'd2);
        next_cycle();
        b_req = 1'b0;
        @(negedge clk);
        chk({tag, " rv+1"}, 32'(b_rvalid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " rv+2"}, 32'(b_rvalid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " rv+3"}, 32'(b_rvalid), 32'd1);
        chk({tag, " rdata"}, b_rdata, exp_rdata);
        chk({tag, " err"}, 32'(b_err), 32'(exp_err));
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_be = '0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_be = '0; b_addr = '0; b_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("a rst gnt", 32'(a_gnt), 32'd0);
        chk("a rst rvalid", 32'(a_rvalid), 32'd0);
        chk("a rst rdata", a_rdata, 32'd0);
        chk("a rst err", 32'(a_err), 32'd0);
        chk("b rst gnt", 32'(b_gnt), 32'd0);
        chk("b rst rvalid", 32'(b_rvalid), 32'd0);
        chk("b rst rdata", b_rdata, 32'd0);
        next_cycle();

        // Write then back-to-back read of 0x10, no stall, latency 1
        a_req = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 32'h10; a_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("a wr gnt", 32'(a_gnt), 32'd1);
        chk("a wr pre rvalid", 32'(a_rvalid), 32'd0);
        next_cycle();
        a_we = 1'b0;
        @(negedge clk);
        chk("a rd gnt", 32'(a_gnt), 32'd1);
        chk("a wr rvalid", 32'(a_rvalid), 32'd1);
        chk("a wr rdata", a_rdata, 32'd0);
        chk("a wr err", 32'(a_err), 32'd0);
        next_cycle();
        a_req = 1'b0;
        @(negedge clk);
        chk("a rd rvalid", 32'(a_rvalid), 32'd1);
        chk("a rd rdata", a_rdata, 32'hDEADBEEF);
        chk("a rd err", 32'(a_err), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("a idle rvalid", 32'(a_rvalid), 32'd0);
        chk("a idle rdata", a_rdata, 32'd0);
        next_cycle();

        // Partial writes and byte-enable zero
        a_single("a pwr", 1'b1, 4'b0101, 32'h10, 32'h11223344, 32'd0, 1'b0);
        a_single("a prd", 1'b0, 4'hF, 32'h10, 32'd0, 32'hDE22BE44, 1'b0);
        a_single("a be0 wr", 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'd0, 1'b0);
        a_single("a be0 rd", 1'b0, 4'hF, 32'h12, 32'd0, 32'hDE22BE44, 1'b0);

        // Out-of-range accesses and the top in-range word
        a_single("a w0", 1'b1, 4'hF, 32'h0, 32'h12345678, 32'd0, 1'b0);
        a_single("a oor rd", 1'b0, 4'hF, 32'h400, 32'd0, 32'd0, 1'b1);
        a_single("a oor wr", 1'b1, 4'hF, 32'h400, 32'hFFFFFFFF, 32'd0, 1'b1);
        a_single("a w0 rd", 1'b0, 4'hF, 32'h3, 32'd0, 32'h12345678, 1'b0);
        a_single("a top wr", 1'b1, 4'hF, 32'h3FC, 32'hCAFEF00D, 32'd0, 1'b0);
        a_single("a top rd", 1'b0, 4'hF, 32'h3FC, 32'd0, 32'hCAFEF00D, 1'b0);

        // Preload words 0..3 on b
        b_single("b pre0", 1'b1, 4'hF, 32'h0, 32'hA0, 32'd0, 1'b0);
        b_single("b pre1", 1'b1, 4'hF, 32'h4, 32'hA1, 32'd0, 1'b0);
        b_single("b pre2", 1'b1, 4'hF, 32'h8, 32'hA2, 32'd0, 1'b0);
        b_single("b pre3", 1'b1, 4'hF, 32'hC, 32'hA3, 32'd0, 1'b0);

        // Stall of two cycles, then four back-to-back reads, latency 3
        b_req = 1'b1; b_we = 1'b0; b_be = 4'hF; b_addr = 32'h0;
        @(negedge clk);
        chk("b stall c1 gnt", 32'(b_gnt), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("b stall c2 gnt", 32'(b_gnt), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("b stall c3 gnt", 32'(b_gnt), 32'd1);
        next_cycle();
        b_addr = 32'h4;
        @(negedge clk);
        chk("b b2b1 gnt", 32'(b_gnt), 32'd1);
        chk("b b2b1 rvalid", 32'(b_rvalid), 32'd0);
        next_cycle();
        b_addr = 32'h8;
        @(negedge clk);
        chk("b b2b2 gnt", 32'(b_gnt), 32'd1);
        chk("b b2b2 rvalid", 32'(b_rvalid), 32'd0);
        next_cycle();
        b_addr = 32'hC;
        @(negedge clk);
        chk("b b2b3 gnt", 32'(b_gnt), 32'd1);
        chk("b r0 rvalid", 32'(b_rvalid), 32'd1);
        chk("b r0 rdata", b_rdata, 32'hA0);
        next_cycle();
        b_req = 1'b0;
        @(negedge clk);
        chk("b r1 rvalid", 32'(b_rvalid), 32'd1);
        chk("b r1 rdata", b_rdata, 32'hA1);
        next_cycle();
        @(negedge clk);
        chk("b r2 rvalid", 32'(b_rvalid), 32'd1);
        chk("b r2 rdata", b_rdata, 32'hA2);
        next_cycle();
        @(negedge clk);
        chk("b r3 rvalid", 32'(b_rvalid), 32'd1);
        chk("b r3 rdata", b_rdata, 32'hA3);
        chk("b r3 err", 32'(b_err), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("b drain rvalid", 32'(b_rvalid), 32'd0);
        chk("b drain rdata", b_rdata, 32'd0);
        next_cycle();

        // Reset with two reads outstanding
        b_req = 1'b1; b_addr = 32'h0;
        @(negedge clk);
        chk("b rs stall1", 32'(b_gnt), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("b rs stall2", 32'(b_gnt), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("b rs gnt0", 32'(b_gnt), 32'd1);
        next_cycle();
        b_addr = 32'h4;
        @(negedge clk);
        chk("b rs gnt1", 32'(b_gnt), 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("b in-rst gnt", 32'(b_gnt), 32'd0);
        chk("a in-rst gnt", 32'(a_gnt), 32'd0);
        next_cycle();
        rst = 1'b0;
        b_addr = 32'h0;
        @(negedge clk);
        chk("b post-rst gnt", 32'(b_gnt), 32'd0);
        chk("b post-rst rv1", 32'(b_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("b post-rst stall", 32'(b_gnt), 32'd0);
        chk("b post-rst rv2", 32'(b_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("b post-rst gnt2", 32'(b_gnt), 32'd1);
        chk("b post-rst rv3", 32'(b_rvalid), 32'd0);
        next_cycle();
        b_req = 1'b0;
        @(negedge clk);
        chk("b post-rst rv4", 32'(b_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("b post-rst rv5", 32'(b_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("b post-rst rd rvalid", 32'(b_rvalid), 32'd1);
        chk("b post-rst rd rdata", b_rdata, 32'hA0);
        chk("b post-rst rd err", 32'(b_err), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("b post-rst end rvalid", 32'(b_rvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
